// File: rtl/hazard_ctrl_if.sv
// Control bundle between the pipeline stages and the hazard controller.
// Pipeline side is the master; the controller is the slave.
interface hazard_ctrl_if #(
   parameter int unsigned CNT_W = 16
);
   logic [4:0]       rs1D;
   logic [4:0]       rs2D;
   logic             useRs1D;
   logic             useRs2D;
   logic [4:0]       rs1E;
   logic [4:0]       rs2E;
   logic [4:0]       rdE;
   logic [4:0]       rdM;
   logic [4:0]       rdW;
   logic             MemReadE;
   logic             RegWriteM;
   logic             RegWriteW;
   logic             PCSrc_final;
   logic             halt_req;
   logic             step_req;
   logic             clr_cnt;
   logic             StallF;
   logic             StallD;
   logic             FlushD;
   logic             FlushE;
   logic             FlushM;
   logic [1:0]       ForwardAE;
   logic [1:0]       ForwardBE;
   logic             halted;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output rs1D, rs2D, useRs1D, useRs2D, rs1E, rs2E, rdE, rdM, rdW,
             MemReadE, RegWriteM, RegWriteW, PCSrc_final, halt_req, step_req, clr_cnt,
      input  StallF, StallD, FlushD, FlushE, FlushM, ForwardAE, ForwardBE,
             halted, stall_cnt, flush_cnt
   );

   modport slave (
      input  rs1D, rs2D, useRs1D, useRs2D, rs1E, rs2E, rdE, rdM, rdW,
             MemReadE, RegWriteM, RegWriteW, PCSrc_final, halt_req, step_req, clr_cnt,
      output StallF, StallD, FlushD, FlushE, FlushM, ForwardAE, ForwardBE,
             halted, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use stall, EX forwarding,
// taken-branch flush, debug halt/single-step drain and saturating event counters.
module hazard_ctrl #(
   parameter int unsigned CNT_W        = 16,
   parameter int unsigned DRAIN_CYCLES = 4
) (
   input  logic          clk,
   input  logic          rst,
   hazard_ctrl_if.slave  bus
);

   localparam int unsigned DCNT_W    = 3;
   localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DRAIN_CYCLES - 1);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2,
      STEP   = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
   logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;

   logic       lu_c;
   logic       br_c;
   logic       stall_f_c, stall_d_c, flush_d_c, flush_e_c, flush_m_c, halted_c;
   logic [1:0] fwd_a_c, fwd_b_c;

   assign br_c = bus.PCSrc_final;
   assign lu_c = bus.MemReadE && (bus.rdE != 5'd0) &&
                 ((bus.useRs1D && (bus.rdE == bus.rs1D)) ||
                  (bus.useRs2D && (bus.rdE == bus.rs2D)));

   // State, drain counter and event counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= RUN;
         dcnt_q      <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         dcnt_q      <= dcnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Next state; the drain counter only advances on cycles the pipeline actually moves
   always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      case (state_q)
         RUN: begin
            if (bus.halt_req) begin
               state_d = DRAIN;
               dcnt_d  = '0;
            end
         end
         DRAIN: begin
            if (!bus.halt_req) begin
               state_d = RUN;
            end else if (!lu_c && !br_c) begin
               if (dcnt_q == DCNT_LAST) begin
                  state_d = HALTED;
                  dcnt_d  = '0;
               end else begin
                  dcnt_d = dcnt_q + DCNT_W'(1);
               end
            end
         end
         HALTED: begin
            if (!bus.halt_req) begin
               state_d = RUN;
            end else if (bus.step_req) begin
               state_d = STEP;
            end
         end
         STEP: begin
            state_d = DRAIN;
            dcnt_d  = '0;
         end
         default: begin
            state_d = RUN;
            dcnt_d  = '0;
         end
      endcase
   end

   // Counters saturate at all-ones; clear has priority
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (bus.clr_cnt) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
      end else begin
         if (lu_c && !br_c && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
         if (br_c && !(&flush_cnt_q))          flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   // Pipeline controls: branch beats load-use, which beats the halt/drain bubbles
   always_comb begin
      stall_f_c = 1'b0;
      stall_d_c = 1'b0;
      flush_d_c = 1'b0;
      flush_e_c = 1'b0;
      flush_m_c = 1'b0;
      halted_c  = 1'b0;
      fwd_a_c   = 2'b00;
      fwd_b_c   = 2'b00;
      if (rst) begin
         if (bus.RegWriteM && (bus.rdM != 5'd0) && (bus.rdM == bus.rs1E))      fwd_a_c = 2'b10;
         else if (bus.RegWriteW && (bus.rdW != 5'd0) && (bus.rdW == bus.rs1E)) fwd_a_c = 2'b01;
         if (bus.RegWriteM && (bus.rdM != 5'd0) && (bus.rdM == bus.rs2E))      fwd_b_c = 2'b10;
         else if (bus.RegWriteW && (bus.rdW != 5'd0) && (bus.rdW == bus.rs2E)) fwd_b_c = 2'b01;

         if (br_c) begin
            flush_d_c = 1'b1;
            flush_e_c = 1'b1;
            flush_m_c = 1'b1;
         end else if (lu_c) begin
            stall_f_c = 1'b1;
            stall_d_c = 1'b1;
            flush_e_c = 1'b1;
         end else if ((state_q == DRAIN) || (state_q == HALTED)) begin
            stall_f_c = 1'b1;
            flush_d_c = 1'b1;
         end
         halted_c = (state_q == HALTED);
      end
   end

   assign bus.StallF    = stall_f_c;
   assign bus.StallD    = stall_d_c;
   assign bus.FlushD    = flush_d_c;
   assign bus.FlushE    = flush_e_c;
   assign bus.FlushM    = flush_m_c;
   assign bus.ForwardAE = fwd_a_c;
   assign bus.ForwardBE = fwd_b_c;
   assign bus.halted    = halted_c;
   assign bus.stall_cnt = stall_cnt_q;
   assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: expected control vectors are queued per cycle
// as stimulus is applied and compared once the combinational outputs settle.
module tb_hazard_ctrl;

   localparam int unsigned CNT_W = 16;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_err;
   logic [9:0] sb_q[$];

   hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

   hazard_ctrl #(.CNT_W(CNT_W), .DRAIN_CYCLES(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {StallF, StallD, FlushD, FlushE, FlushM, ForwardAE, ForwardBE, halted}
   function automatic logic [9:0] ex(input logic sf, input logic sd, input logic fd,
                                     input logic fe, input logic fm, input logic [1:0] fa,
                                     input logic [1:0] fb, input logic h);
      return {sf, sd, fd, fe, fm, fa, fb, h};
   endfunction

   function automatic logic [9:0] obs_vec();
      return {bus.StallF, bus.StallD, bus.FlushD, bus.FlushE, bus.FlushM,
              bus.ForwardAE, bus.ForwardBE, bus.halted};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called just after a rising edge with inputs already set for this cycle
   task automatic cyc(input string tag, input logic [9:0] exp);
      sb_q.push_back(exp);
      #2;
      check(tag, 32'(obs_vec()), 32'(sb_q.pop_front()));
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.rs1D = '0; bus.rs2D = '0; bus.useRs1D = 1'b0; bus.useRs2D = 1'b0;
      bus.rs1E = '0; bus.rs2E = '0; bus.rdE = '0; bus.rdM = '0; bus.rdW = '0;
      bus.MemReadE = 1'b0; bus.RegWriteM = 1'b0; bus.RegWriteW = 1'b0;
      bus.PCSrc_final = 1'b0; bus.step_req = 1'b0; bus.clr_cnt = 1'b0;
   endtask

   task automatic set_lu();
      bus.MemReadE = 1'b1; bus.rdE = 5'd3; bus.rs2D = 5'd3; bus.useRs2D = 1'b1;
   endtask

   initial begin
      logic [9:0] e_run, e_drn, e_hlt, e_lu, e_br;
      e_run = ex(0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
      e_drn = ex(1, 0, 1, 0, 0, 2'b00, 2'b00, 0);
      e_hlt = ex(1, 0, 1, 0, 0, 2'b00, 2'b00, 1);
      e_lu  = ex(1, 1, 0, 1, 0, 2'b00, 2'b00, 0);
      e_br  = ex(0, 0, 1, 1, 1, 2'b00, 2'b00, 0);
      n_checks = 0;
      n_err    = 0;
      rst = 1'b0;
      bus.halt_req = 1'b0;
      idle();

      // Hazard inputs present while in reset must not reach the outputs
      #2;
      bus.RegWriteM = 1'b1; bus.rdM = 5'd5; bus.rs1E = 5'd5;
      set_lu();
      #1;
      check("rst_outputs", 32'(obs_vec()), 32'(e_run));
      check("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
      check("rst_flush_cnt", 32'(bus.flush_cnt), 32'd0);
      idle();
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;

      // Forwarding priority and x0 exclusion
      bus.RegWriteM = 1'b1; bus.rdM = 5'd5; bus.RegWriteW = 1'b1; bus.rdW = 5'd5; bus.rs1E = 5'd5;
      cyc("fwd_a_m", ex(0, 0, 0, 0, 0, 2'b10, 2'b00, 0));
      bus.rdM = 5'd0;
      cyc("fwd_a_w", ex(0, 0, 0, 0, 0, 2'b01, 2'b00, 0));
      bus.rs1E = 5'd0; bus.rdW = 5'd0;
      cyc("fwd_a_none", e_run);
      bus.rdM = 5'd7; bus.rdW = 5'd7; bus.rs1E = 5'd7; bus.rs2E = 5'd7;
      cyc("fwd_ab_m", ex(0, 0, 0, 0, 0, 2'b10, 2'b10, 0));
      bus.RegWriteM = 1'b0;
      cyc("fwd_ab_w", ex(0, 0, 0, 0, 0, 2'b01, 2'b01, 0));
      bus.rs1E = 5'd9;
      cyc("fwd_b_only", ex(0, 0, 0, 0, 0, 2'b00, 2'b01, 0));
      idle();

      // Load-use: one bubble, only when the register is really read
      set_lu();
      cyc("lu_stall", e_lu);
      check("lu_stall_cnt", 32'(bus.stall_cnt), 32'd1);
      bus.useRs2D = 1'b0;
      cyc("lu_unused", e_run);
      bus.useRs2D = 1'b0; bus.useRs1D = 1'b1; bus.rs1D = 5'd3; bus.rdE = 5'd0;
      cyc("lu_rd_x0", e_run);
      check("lu_stall_cnt_hold", 32'(bus.stall_cnt), 32'd1);
      idle();

      // Branch beats load-use
      set_lu();
      bus.PCSrc_final = 1'b1;
      cyc("br_over_lu", e_br);
      check("br_flush_cnt", 32'(bus.flush_cnt), 32'd1);
      check("br_stall_cnt", 32'(bus.stall_cnt), 32'd1);
      idle();

      // step_req outside HALTED is ignored
      bus.step_req = 1'b1;
      cyc("step_in_run", e_run);
      bus.step_req = 1'b0;
      cyc("step_in_run2", e_run);

      // Halt, then single step
      bus.halt_req = 1'b1;
      cyc("halt_req_run", e_run);
      for (int i = 0; i < 4; i++) cyc("halt_drain", e_drn);
      bus.step_req = 1'b1;
      cyc("halted", e_hlt);
      bus.step_req = 1'b0;
      cyc("step_cycle", e_run);
      for (int i = 0; i < 4; i++) cyc("step_drain", e_drn);
      cyc("step_rehalt", e_hlt);
      bus.halt_req = 1'b0;
      cyc("release_hlt", e_hlt);
      cyc("release_run", e_run);

      // Load-use during drain holds the drain counter
      bus.halt_req = 1'b1;
      cyc("dl_run", e_run);
      cyc("dl_d0", e_drn);
      set_lu();
      cyc("dl_lu", e_lu);
      check("dl_stall_cnt", 32'(bus.stall_cnt), 32'd2);
      idle();
      for (int i = 0; i < 3; i++) cyc("dl_drain", e_drn);
      cyc("dl_halted", e_hlt);
      bus.halt_req = 1'b0;
      cyc("dl_release", e_hlt);

      // Taken branch during drain redirects the PC and holds the drain counter
      bus.halt_req = 1'b1;
      cyc("db_run", e_run);
      cyc("db_d0", e_drn);
      bus.PCSrc_final = 1'b1;
      cyc("db_br", e_br);
      check("db_flush_cnt", 32'(bus.flush_cnt), 32'd2);
      bus.PCSrc_final = 1'b0;
      for (int i = 0; i < 3; i++) cyc("db_drain", e_drn);
      cyc("db_halted", e_hlt);
      bus.halt_req = 1'b0;
      cyc("db_release", e_hlt);
      cyc("db_run2", e_run);

      // Clear has priority over increment
      bus.clr_cnt = 1'b1;
      cyc("clr", e_run);
      check("clr_stall_cnt", 32'(bus.stall_cnt), 32'd0);
      check("clr_flush_cnt", 32'(bus.flush_cnt), 32'd0);
      set_lu();
      cyc("clr_with_lu", e_lu);
      check("clr_wins", 32'(bus.stall_cnt), 32'd0);
      bus.clr_cnt = 1'b0;

      // Saturation
      repeat (65535) @(posedge clk);
      #1;
      check("sat_reach", 32'(bus.stall_cnt), 32'h0000_FFFF);
      repeat (3) @(posedge clk);
      #1;
      check("sat_hold", 32'(bus.stall_cnt), 32'h0000_FFFF);
      check("sat_flush_cnt", 32'(bus.flush_cnt), 32'd0);
      idle();
      bus.clr_cnt = 1'b1;
      cyc("sat_clr", e_run);
      check("sat_cleared", 32'(bus.stall_cnt), 32'd0);
      idle();

      // Asynchronous reset while halted
      bus.halt_req = 1'b1;
      cyc("ar_run", e_run);
      for (int i = 0; i < 4; i++) cyc("ar_drain", e_drn);
      cyc("ar_halted", e_hlt);
      #2;
      rst = 1'b0;
      #1;
      check("ar_outputs", 32'(obs_vec()), 32'(e_run));
      bus.halt_req = 1'b0;
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;
      cyc("ar_run_after", e_run);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
